// File: rtl/enc148_pkg.sv
// enc148_pkg: shared types and helpers for the clocked 74LS148-style encoder.
//   state_t   : two-state present/acknowledge FSM encoding
//   N_REQ     : number of request lines
//   IDX_W     : width of the encoded index
//   SYNC_RESET_VAL : value synchroniser flops take in reset (inactive level)
//   prio_idx  : index of the highest-priority set bit of a request vector
package enc148_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   localparam int unsigned N_REQ          = 8;
   localparam int unsigned IDX_W          = 3;
   localparam logic        SYNC_RESET_VAL = 1'b1;

   // prio_high7 = 1: bit 7 wins (74LS148 order); 0: bit 0 wins.
   // The scan direction makes the last set bit visited the winner.
   function automatic logic [IDX_W-1:0] prio_idx(input logic [N_REQ-1:0] pend,
                                                 input logic             prio_high7);
      logic [IDX_W-1:0] r;
      r = '0;
      if (prio_high7) begin
         for (int unsigned k = 0; k < N_REQ; k++)
            if (pend[k]) r = IDX_W'(k);
      end else begin
         for (int unsigned k = N_REQ; k > 0; k--)
            if (pend[k-1]) r = IDX_W'(k-1);
      end
      return r;
   endfunction

endpackage

// File: rtl/encode_74ls148_seq_sync_bit_n.sv
// sync_bit_n: SYNC_STAGES-deep single-bit synchroniser for active-low lines.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset; all stages reset to 1 (inactive)
//   d   : asynchronous input
//   q   : synchronised output (last stage)
// SYNC_STAGES legal range 1..4.
module sync_bit_n
   import enc148_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] sr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr <= {SYNC_STAGES{SYNC_RESET_VAL}};
      end else begin
         sr[0] <= d;
         for (int unsigned k = 1; k < SYNC_STAGES; k++)
            sr[k] <= sr[k-1];
      end
   end

   assign q = sr[SYNC_STAGES-1];

endmodule

// File: rtl/encode_74ls148_seq.sv
// encode_74ls148_seq: clocked 8-to-3 priority encoder with 74LS148 pin polarity.
// Requests are synchronised, latched into sticky pending bits, and presented
// one at a time by a present/acknowledge FSM.
//   clk   : system clock, rising edge
//   rst   : asynchronous active-high reset
//   I_n   : active-low request lines (asynchronous)
//   EI_n  : active-low enable input (asynchronous)
//   ack   : consumer acknowledges the presented code (synchronous)
//   A_n   : active-low encoded index of the presented request (registered)
//   GS_n  : active-low group select, low while a code is presented (registered)
//   EO_n  : active-low cascade enable for a lower-priority device (registered)
//   valid : active-high copy of ~GS_n (registered)
// Build option: ENC148_EDGE_DETECT_EN -- pend bits set only on a synchronised
// falling edge of each request line instead of on its low level.
module encode_74ls148_seq
   import enc148_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter bit          PRIO_HIGH7  = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] I_n,
   input  logic       EI_n,
   input  logic       ack,
   output logic [2:0] A_n,
   output logic       GS_n,
   output logic       EO_n,
   output logic       valid
);

   logic [N_REQ-1:0] is_s;
   logic             eis;
   logic [N_REQ-1:0] pend;
   logic [N_REQ-1:0] set_v;
   logic [N_REQ-1:0] clr_v;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] win;
   state_t           state;

   for (genvar g = 0; g < N_REQ; g++) begin : g_sync
      sync_bit_n #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk (clk),
         .rst (rst),
         .d   (I_n[g]),
         .q   (is_s[g])
      );
   end

   sync_bit_n #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ei (
      .clk (clk),
      .rst (rst),
      .d   (EI_n),
      .q   (eis)
   );

`ifdef ENC148_EDGE_DETECT_EN
   logic [N_REQ-1:0] is_prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) is_prev <= {N_REQ{SYNC_RESET_VAL}};
      else     is_prev <= is_s;
   end

   always_comb begin
      set_v = is_prev & ~is_s & {N_REQ{~eis}};
   end
`else
   always_comb begin
      set_v = ~is_s & {N_REQ{~eis}};
   end
`endif

   always_comb begin
      clr_v = '0;
      if (state == PRESENT && ack) clr_v[idx] = 1'b1;
      win = prio_idx(pend, PRIO_HIGH7);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         pend  <= '0;
         idx   <= '0;
         A_n   <= '1;
         GS_n  <= 1'b1;
         EO_n  <= 1'b1;
         valid <= 1'b0;
      end else begin
         // Set is OR-ed after the clear so a still-asserted line is re-pended.
         pend <= (pend & ~clr_v) | set_v;
         EO_n <= ~(~eis && pend == '0 && state == IDLE && set_v == '0);
         case (state)
            IDLE: begin
               if (pend != '0 && !eis) begin
                  idx   <= win;
                  A_n   <= ~win;
                  GS_n  <= 1'b0;
                  valid <= 1'b1;
                  state <= PRESENT;
               end
            end
            PRESENT: begin
               if (ack) begin
                  A_n   <= '1;
                  GS_n  <= 1'b1;
                  valid <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_encode_74ls148_seq.sv
// Testbench for encode_74ls148_seq. Two instances: default priority order
// and PRIO_HIGH7 = 0. Expected codes are queued when stimulus is driven and
// popped when the DUT presents a code.
module tb_encode_74ls148_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] I_n;
   logic       EI_n;
   logic       ack;
   logic [2:0] A_n;
   logic       GS_n;
   logic       EO_n;
   logic       valid;

   logic [7:0] I_n_lo;
   logic       EI_n_lo;
   logic       ack_lo;
   logic [2:0] A_n_lo;
   logic       GS_n_lo;
   logic       EO_n_lo;
   logic       valid_lo;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   logic [2:0]  exp_q[$];
   logic [2:0]  e;

   always #5 clk = ~clk;

   encode_74ls148_seq #(.SYNC_STAGES(2), .PRIO_HIGH7(1'b1)) dut (
      .clk(clk), .rst(rst), .I_n(I_n), .EI_n(EI_n), .ack(ack),
      .A_n(A_n), .GS_n(GS_n), .EO_n(EO_n), .valid(valid)
   );

   encode_74ls148_seq #(.SYNC_STAGES(2), .PRIO_HIGH7(1'b0)) dut_lo (
      .clk(clk), .rst(rst), .I_n(I_n_lo), .EI_n(EI_n_lo), .ack(ack_lo),
      .A_n(A_n_lo), .GS_n(GS_n_lo), .EO_n(EO_n_lo), .valid(valid_lo)
   );

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic tick(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Release all requests and acknowledge whatever is still pending.
   task automatic drain();
      I_n  = '1;
      EI_n = 1'b0;
      tick(3);
      for (int unsigned k = 0; k < 12; k++) begin
         if (GS_n == 1'b0) begin
            ack = 1'b1;
            tick(1);
            ack = 1'b0;
         end
         tick(1);
      end
      exp_q.delete();
   endtask

   task automatic test_reset_start();
      n_vec++;
      if ({A_n, GS_n, EO_n, valid} !== 6'b111_110) begin
         n_err++;
         $display("FAIL reset_start: got A_n=%b GS_n=%b EO_n=%b valid=%b, need 111 1 1 0",
                  A_n, GS_n, EO_n, valid);
      end
      rst = 1'b0;
      tick(3);
      n_vec++;
      if (EO_n !== 1'b0 || GS_n !== 1'b1) begin
         n_err++;
         $display("FAIL idle_after_reset: got EO_n=%b GS_n=%b, need 0 1", EO_n, GS_n);
      end
   endtask

   task automatic test_single();
      I_n = 8'b1101_1111;
      exp_q.push_back(3'b010);
      tick(3);
      n_vec++;
      if (GS_n !== 1'b1) begin
         n_err++;
         $display("FAIL single_early: got GS_n=%b after 3 edges, need 1", GS_n);
      end
      tick(1);
      e = exp_q.pop_front();
      n_vec++;
      if (GS_n !== 1'b0 || A_n !== e || valid !== 1'b1) begin
         n_err++;
         $display("FAIL single_code: got GS_n=%b A_n=%b valid=%b, need 0 %b 1", GS_n, A_n, valid, e);
      end
      I_n = '1;
      tick(2);
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
      n_vec++;
      if (GS_n !== 1'b1 || EO_n !== 1'b1 || valid !== 1'b0) begin
         n_err++;
         $display("FAIL single_ack: got GS_n=%b EO_n=%b valid=%b, need 1 1 0", GS_n, EO_n, valid);
      end
      tick(1);
      n_vec++;
      if (EO_n !== 1'b0 || GS_n !== 1'b1) begin
         n_err++;
         $display("FAIL single_eo: got EO_n=%b GS_n=%b, need 0 1", EO_n, GS_n);
      end
   endtask

   task automatic test_priority_freeze();
      I_n = 8'b1111_1011;
      exp_q.push_back(3'b101);
      tick(4);
      e = exp_q.pop_front();
      n_vec++;
      if (GS_n !== 1'b0 || A_n !== e) begin
         n_err++;
         $display("FAIL prio_first: got GS_n=%b A_n=%b, need 0 %b", GS_n, A_n, e);
      end
      I_n = 8'b1011_1011;
      tick(4);
      n_vec++;
      if (GS_n !== 1'b0 || A_n !== e) begin
         n_err++;
         $display("FAIL prio_frozen: got GS_n=%b A_n=%b, need 0 %b", GS_n, A_n, e);
      end
      exp_q.push_back(3'b001);
      I_n = 8'b1011_1111;
      tick(2);
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
      n_vec++;
      if (GS_n !== 1'b1) begin
         n_err++;
         $display("FAIL prio_gap: got GS_n=%b, need 1", GS_n);
      end
      tick(1);
      e = exp_q.pop_front();
      n_vec++;
      if (GS_n !== 1'b0 || A_n !== e) begin
         n_err++;
         $display("FAIL prio_second: got GS_n=%b A_n=%b, need 0 %b", GS_n, A_n, e);
      end
      drain();
   endtask

   task automatic test_disable();
      EI_n = 1'b1;
      I_n  = 8'h00;
      tick(6);
      n_vec++;
      if (GS_n !== 1'b1 || EO_n !== 1'b1) begin
         n_err++;
         $display("FAIL disable_hold: got GS_n=%b EO_n=%b, need 1 1", GS_n, EO_n);
      end
      EI_n = 1'b0;
`ifdef ENC148_EDGE_DETECT_EN
      // Lines were already low before enable: no falling edge, nothing pends.
      tick(6);
      n_vec++;
      if (GS_n !== 1'b1) begin
         n_err++;
         $display("FAIL disable_edge: got GS_n=%b, need 1", GS_n);
      end
`else
      exp_q.push_back(3'b000);
      tick(3);
      n_vec++;
      if (GS_n !== 1'b1) begin
         n_err++;
         $display("FAIL enable_early: got GS_n=%b after 3 edges, need 1", GS_n);
      end
      tick(1);
      e = exp_q.pop_front();
      n_vec++;
      if (GS_n !== 1'b0 || A_n !== e) begin
         n_err++;
         $display("FAIL enable_code: got GS_n=%b A_n=%b, need 0 %b", GS_n, A_n, e);
      end
`endif
      drain();
   endtask

   task automatic test_level_edge();
      I_n = 8'b1111_0111;
      exp_q.push_back(3'b100);
      tick(4);
      e = exp_q.pop_front();
      n_vec++;
      if (GS_n !== 1'b0 || A_n !== e) begin
         n_err++;
         $display("FAIL hold_first: got GS_n=%b A_n=%b, need 0 %b", GS_n, A_n, e);
      end
      for (int unsigned k = 0; k < 2; k++) begin
         ack = 1'b1;
         tick(1);
         ack = 1'b0;
`ifdef ENC148_EDGE_DETECT_EN
         tick(3);
         n_vec++;
         if (GS_n !== 1'b1) begin
            n_err++;
            $display("FAIL hold_once[%0d]: got GS_n=%b, need 1", k, GS_n);
         end
`else
         exp_q.push_back(3'b100);
         tick(1);
         e = exp_q.pop_front();
         n_vec++;
         if (GS_n !== 1'b0 || A_n !== e) begin
            n_err++;
            $display("FAIL hold_repend[%0d]: got GS_n=%b A_n=%b, need 0 %b", k, GS_n, A_n, e);
         end
`endif
      end
      drain();
   endtask

   task automatic test_ack_idle_lo();
      // Enable pulse of one cycle: pend set on one edge, FSM disabled the next.
      I_n_lo  = 8'b1110_1101;
      EI_n_lo = 1'b0;
      tick(1);
      EI_n_lo = 1'b1;
      tick(3);
      I_n_lo = '1;
      for (int unsigned k = 0; k < 3; k++) begin
         ack_lo = 1'b1;
         tick(1);
         ack_lo = 1'b0;
         tick(1);
      end
      n_vec++;
      if (GS_n_lo !== 1'b1) begin
         n_err++;
         $display("FAIL lo_idle: got GS_n=%b, need 1", GS_n_lo);
      end
      EI_n_lo = 1'b0;
      exp_q.push_back(3'b110);
      exp_q.push_back(3'b011);
      tick(3);
      e = exp_q.pop_front();
      n_vec++;
      if (GS_n_lo !== 1'b0 || A_n_lo !== e) begin
         n_err++;
         $display("FAIL lo_first: got GS_n=%b A_n=%b, need 0 %b", GS_n_lo, A_n_lo, e);
      end
      ack_lo = 1'b1;
      tick(1);
      ack_lo = 1'b0;
      tick(1);
      e = exp_q.pop_front();
      n_vec++;
      if (GS_n_lo !== 1'b0 || A_n_lo !== e) begin
         n_err++;
         $display("FAIL lo_second: got GS_n=%b A_n=%b, need 0 %b", GS_n_lo, A_n_lo, e);
      end
      ack_lo = 1'b1;
      tick(1);
      ack_lo = 1'b0;
      tick(1);
      n_vec++;
      if (GS_n_lo !== 1'b1 || EO_n_lo !== 1'b0) begin
         n_err++;
         $display("FAIL lo_empty: got GS_n=%b EO_n=%b, need 1 0", GS_n_lo, EO_n_lo);
      end
   endtask

   task automatic test_reset_present();
      I_n = 8'h7F;
      exp_q.push_back(3'b000);
      tick(4);
      e = exp_q.pop_front();
      n_vec++;
      if (GS_n !== 1'b0 || A_n !== e) begin
         n_err++;
         $display("FAIL rst_pre: got GS_n=%b A_n=%b, need 0 %b", GS_n, A_n, e);
      end
      #2;
      rst = 1'b1;
      #1;
      n_vec++;
      if ({A_n, GS_n, EO_n, valid} !== 6'b111_110) begin
         n_err++;
         $display("FAIL rst_async: got A_n=%b GS_n=%b EO_n=%b valid=%b, need 111 1 1 0",
                  A_n, GS_n, EO_n, valid);
      end
      I_n = '1;
      tick(1);
      rst = 1'b0;
      tick(3);
      n_vec++;
      if (GS_n !== 1'b1 || EO_n !== 1'b0) begin
         n_err++;
         $display("FAIL rst_pend_lost: got GS_n=%b EO_n=%b, need 1 0", GS_n, EO_n);
      end
      tick(3);
      n_vec++;
      if (GS_n !== 1'b1) begin
         n_err++;
         $display("FAIL rst_no_present: got GS_n=%b, need 1", GS_n);
      end
   endtask

   initial begin
      rst     = 1'b1;
      I_n     = '1;
      EI_n    = 1'b0;
      ack     = 1'b0;
      I_n_lo  = '1;
      EI_n_lo = 1'b1;
      ack_lo  = 1'b0;
      tick(2);
      test_reset_start();
      test_single();
      test_priority_freeze();
      test_disable();
      test_level_edge();
      test_ack_idle_lo();
      test_reset_present();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
